// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t           : register address type for the default register count
//   addr_width()         : address width for a given register count (minimum 1)
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Keeps the address width at least 1 bit for a degenerate single-register file.
  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with a registered busy count.
//   clk, rst           : clock, synchronous active-high reset
//   set_en, set_addr   : mark a register as having an in-flight producer
//   clr_en, clr_addr   : producer completed, clear the register's busy bit
//   busy_vec           : registered busy bit per register
//   busy_cnt           : registered popcount of busy_vec
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      busy_cnt
);

  logic             set_ok;
  logic             clr_ok;
  logic [NREGS-1:0] set_hit;
  logic [NREGS-1:0] clr_hit;
  logic [NREGS-1:0] busy_nxt;
  logic             cnt_inc;
  logic             cnt_dec;

  // Out-of-range addresses and (optionally) r0 never touch the scoreboard.
  assign set_ok = set_en && (32'(set_addr) < NREGS) && !(ZERO_REG && (set_addr == '0));
  assign clr_ok = clr_en && (32'(clr_addr) < NREGS) && !(ZERO_REG && (clr_addr == '0));

  // One-hot decode of the set/clear targets.
  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      set_hit[i] = set_ok && (set_addr == AW'(i));
      clr_hit[i] = clr_ok && (clr_addr == AW'(i));
    end
  end

  // Set is applied after clear so a new producer supersedes a completing one.
  assign busy_nxt = (busy_vec & ~clr_hit) | set_hit;

  // At most one bit rises and one bit falls per cycle, so the count moves by -1/0/+1.
  assign cnt_inc = |(set_hit & ~busy_vec);
  assign cnt_dec = |(clr_hit & busy_vec & ~set_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with busy scoreboard.
//   clk, rst             : clock, synchronous active-high reset
//   rd_addr / rd_data    : NRD combinational read ports, packed per port
//   rd_busy              : per-port busy flag of the addressed register
//   wr_en/wr_addr/wr_data: writeback; also clears the register's busy bit
//   issue_en/issue_addr  : claims a register for an in-flight producer
//   busy_cnt             : registered count of busy registers
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic             wr_ok;

  assign wr_ok = wr_en && (32'(wr_addr) < NREGS) && !(ZERO_REG && (wr_addr == '0));

  // Storage array; reset clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_en),
    .set_addr (issue_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  // Read muxes: reset / r0 / out-of-range read as zero, then bypass, then the array.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[gi*AW +: AW];

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (!rst && !(ZERO_REG && (addr == '0)) && (32'(addr) < NREGS)) begin
        if (BYPASS && wr_en && (wr_addr == addr)) begin
          data = wr_data;
        end else begin
          data = regs[addr];
          busy = busy_vec[addr];
        end
      end
    end

    assign rd_data[gi*XLEN +: XLEN] = data;
    assign rd_busy[gi]              = busy;
  end

endmodule
